// File: rtl/systolic_array_controller.sv
// Tile sequencer for an output-stationary systolic array: clear, feed K steps,
// flush the skewed wavefront, then drain COLS columns through the PE shift chain.
module systolic_array_controller #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int KW   = 8,
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [KW-1:0] feed_k,
    output logic          feed_valid,
    output logic          pe_rst_output,
    output logic          pe_shift_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_col,
    output logic [2:0]    dbg_state_o
);

    localparam int FW = $clog2(ROWS + COLS);

    // Debug encoding: IDLE reads as 0 on dbg_state_o.
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] feed_k_q, feed_k_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic          busy_q, done_q, in_ready_q, out_valid_q, clear_q;
    logic          fire, shift;

    // Handshakes: a feed step transfers when in_valid && in_ready; a drain
    // column transfers when out_valid && out_ready. Both are masked by reset.
    assign fire  = in_valid && in_ready_q;
    assign shift = out_valid_q && out_ready;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        feed_k_d  = feed_k_q;
        flush_d   = flush_q;
        out_col_d = out_col_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = k_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = (k_q != '0) ? S_FEED : S_DRAIN;
            S_FEED: begin
                if (fire) begin
                    if (feed_k_q == k_q - KW'(1)) begin
                        feed_k_d = '0;
                        state_d  = S_FLUSH;
                    end else begin
                        feed_k_d = feed_k_q + KW'(1);
                    end
                end
            end
            // Last operand lands in the far-corner PE ROWS+COLS-2 cycles after its fire.
            S_FLUSH: begin
                if (flush_q == FW'(ROWS + COLS - 2)) begin
                    flush_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            S_DRAIN: begin
                if (shift) begin
                    if (out_col_q == CW'(COLS - 1)) begin
                        out_col_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        out_col_d = out_col_q + CW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            feed_k_q    <= '0;
            flush_q     <= '0;
            out_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            feed_k_q    <= feed_k_d;
            flush_q     <= flush_d;
            out_col_q   <= out_col_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            in_ready_q  <= (state_d == S_FEED);
            out_valid_q <= (state_d == S_DRAIN);
            clear_q     <= (state_d == S_CLEAR);
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign in_ready      = in_ready_q;
    assign feed_k        = feed_k_q;
    assign feed_valid    = fire && !rst;
    assign pe_rst_output = clear_q || rst;
    assign pe_shift_out  = shift && !rst;
    assign out_valid     = out_valid_q;
    assign out_col       = out_col_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_systolic_array_controller.sv
// Randomized bench for systolic_array_controller: a phase-timeline model predicts
// every output cycle by cycle, plus feed_k/out_col scoreboards and tile totals.
module tb_systolic_array_controller;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KW   = 8;
    localparam int CW   = 2;
    localparam int NC   = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy, done, in_valid, in_ready;
    logic [KW-1:0] feed_k;
    logic          feed_valid, pe_rst_output, pe_shift_out, out_valid, out_ready;
    logic [CW-1:0] out_col;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    bit iv_a[NC];
    bit or_a[NC];
    logic [KW-1:0] exp_q[$];
    logic [CW-1:0] col_q[$];

    systolic_array_controller #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .feed_k(feed_k), .feed_valid(feed_valid), .pe_rst_output(pe_rst_output),
        .pe_shift_out(pe_shift_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(bit b, bit d, bit ir, bit fv, bit pr, bit sh, bit ov,
                                         int fk, int oc);
        logic [7:0] fk8;
        logic [1:0] oc2;
        fk8 = fk[7:0];
        oc2 = oc[1:0];
        return {9'd0, b, d, ir, fv, pr, sh, ov, fk8, 6'd0, oc2};
    endfunction

    // mode 0: always asserted; mode 1: random with roughly 2/3 duty
    task automatic fill(input int iv_mode, input int or_mode);
        for (int i = 0; i < NC; i++) begin
            iv_a[i] = (iv_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            or_a[i] = (or_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    endtask

    // Cycle 0 is the IDLE cycle where start is presented; rst_c >= 0 aborts the tile there.
    task automatic run_tile(input string name, input int k, input int glitch_c, input int rst_c);
        int cf, d0, cd, c, n, fires, shifts, last;
        int busy_cnt, fire_cnt, shift_cnt;
        bit e_b, e_d, e_ir, e_fv, e_pr, e_sh, e_ov;
        int e_fk, e_oc;

        cf = 1;
        c = 2;
        fires = 0;
        while (fires < k) begin
            if (c >= NC - 80) iv_a[c] = 1'b1;
            if (iv_a[c]) begin
                fires++;
                cf = c;
            end
            c++;
        end
        d0 = (k > 0) ? cf + ROWS + COLS : 2;
        c = d0;
        n = 0;
        cd = d0;
        while (n < COLS) begin
            if (c >= NC - 8) or_a[c] = 1'b1;
            if (or_a[c]) begin
                n++;
                cd = c;
            end
            c++;
        end
        last = (rst_c >= 0) ? rst_c + 1 : cd + 2;

        exp_q.delete();
        col_q.delete();
        for (int i = 0; i < k; i++) exp_q.push_back(KW'(i));
        for (int i = 0; i < COLS; i++) col_q.push_back(CW'(i));

        fires = 0;
        shifts = 0;
        busy_cnt = 0;
        fire_cnt = 0;
        shift_cnt = 0;
        for (c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            rst       = (c == rst_c);
            start     = (c == 0) || (c == glitch_c);
            k_len     = (c == 0) ? KW'(k) : KW'($urandom_range(1, 255));
            in_valid  = iv_a[c];
            out_ready = or_a[c];
            @(negedge clk);

            {e_b, e_d, e_ir, e_fv, e_pr, e_sh, e_ov} = '0;
            e_fk = 0;
            e_oc = 0;
            if (rst_c >= 0 && c > rst_c) begin
                // aborted tile: everything idle
            end else if (c == 1) begin
                e_b = 1; e_pr = 1;
            end else if (k > 0 && c >= 2 && c <= cf) begin
                e_b = 1; e_ir = 1; e_fv = iv_a[c]; e_fk = fires;
            end else if (c >= 2 && c < d0) begin
                e_b = 1;
            end else if (c >= d0 && c <= cd) begin
                e_b = 1; e_ov = 1; e_sh = or_a[c]; e_oc = shifts;
            end else if (c == cd + 1) begin
                e_b = 1; e_d = 1;
            end

            if (c == rst_c) begin
                check($sformatf("%s_rst_cycle%0d", name, c),
                      {29'd0, pe_rst_output, feed_valid, pe_shift_out}, 32'h4);
            end else begin
                check($sformatf("%s_cyc%0d", name, c),
                      pack(busy, done, in_ready, feed_valid, pe_rst_output, pe_shift_out,
                           out_valid, int'(feed_k), int'(out_col)),
                      pack(e_b, e_d, e_ir, e_fv, e_pr, e_sh, e_ov, e_fk, e_oc));
                if (feed_valid) begin
                    fire_cnt++;
                    if (exp_q.size() > 0) check($sformatf("%s_sb_feed_k", name), feed_k, exp_q.pop_front());
                end
                if (pe_shift_out) begin
                    shift_cnt++;
                    if (col_q.size() > 0) check($sformatf("%s_sb_out_col", name), out_col, col_q.pop_front());
                end
                if (busy) busy_cnt++;
            end
            if (e_fv) fires++;
            if (e_sh) shifts++;
        end

        rst = 1'b0;
        start = 1'b0;
        if (rst_c < 0) begin
            check({name, "_fire_cnt"}, fire_cnt, k);
            check({name, "_shift_cnt"}, shift_cnt, COLS);
            check({name, "_busy_len"}, busy_cnt, cd + 1);
            check({name, "_sb_left"}, exp_q.size() + col_q.size(), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        k_len = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_vec", pack(busy, done, in_ready, feed_valid, pe_rst_output, pe_shift_out,
                                out_valid, int'(feed_k), int'(out_col)),
              pack(0, 0, 0, 0, 1, 0, 0, 0, 0));
        check("reset_state_idle", dbg_state, 3'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_pe_rst", pe_rst_output, 1'b0);

        // nominal: 1 clear, 3 fires, 7 flush, 4 shifts, done; busy 16 cycles
        fill(0, 0);
        run_tile("nominal", 3, -1, -1);

        // feed stall on the 2nd and 3rd FEED cycles
        fill(0, 0);
        iv_a[3] = 1'b0;
        iv_a[4] = 1'b0;
        run_tile("feed_stall", 4, -1, -1);

        // drain backpressure for 3 cycles after the first shift (first shift at cycle 12)
        fill(0, 0);
        or_a[13] = 1'b0;
        or_a[14] = 1'b0;
        or_a[15] = 1'b0;
        run_tile("backpressure", 3, -1, -1);

        fill(1, 0);
        run_tile("zero_len", 0, -1, -1);

        // reset during DRAIN after 2 shifts: k=2 drains from cycle 11, shifts at 11 and 12
        fill(0, 0);
        run_tile("mid_reset", 2, -1, 13);
        fill(0, 0);
        run_tile("after_reset", 3, -1, -1);

        fill(0, 0);
        run_tile("start_busy", 5, 3, -1);

        fill(0, 1);
        run_tile("k_max", 255, -1, -1);

        for (int t = 0; t < 20; t++) begin
            fill(1, 1);
            run_tile($sformatf("rand%0d", t), $urandom_range(0, 24),
                     ($urandom_range(0, 1) != 0) ? $urandom_range(2, 6) : -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_array_controller.md
Name: systolic_array_controller

Overview:
- Sequences one output-stationary matrix-multiply tile on a ROWS x COLS grid of sign-magnitude MAC processing elements.
- Per tile: clears the PE accumulators, then streams K reduction steps into the array edge under a valid/ready handshake.
- Waits for the skewed wavefront to finish, then drains the accumulators column by column through the PE shift chain with output backpressure.
- Sits between the operand staging buffers (which apply the per-row/per-column skew) and the array; it drives the array-wide rst_output and shift_out controls.

Parameters:
- ROWS, 4, PE rows in the array (>=1).
- COLS, 4, PE columns in the array; equals the number of drain shifts (>=1).
- KW, 8, width of the reduction-length field and the feed index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a tile; sampled only in IDLE.
- k_len  in  KW  reduction length K; captured when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the tile completes.
- in_valid  in  1  staging buffers present operands for step feed_k.
- in_ready  out  1  high in FEED.
- feed_k  out  KW  index of the next reduction step to consume.
- feed_valid  out  1  in_valid && in_ready; drives the unskewed wgt_valid/act_valid at the array edge.
- pe_rst_output  out  1  to every PE rst_output.
- pe_shift_out  out  1  to every PE shift_out.
- out_valid  out  1  leftmost-column accumulators are presented as tile output.
- out_ready  in  1  consumer accepts the presented column.
- out_col  out  clog2(COLS) (min 1)  drain index; 0 = first column shifted out.

Behaviour:
- FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- Reset (rst=1) from any state, including mid-tile:
  - Next state IDLE; all counters 0.
  - busy, done, in_ready, feed_valid, pe_shift_out and out_valid are 0.
  - pe_rst_output is 1 combinationally while rst is high, so the PEs are also cleared.
  - A partially drained tile is discarded.
- IDLE:
  - start=1 latches k_len into K and moves to CLEAR.
  - start in any other state is ignored.
- CLEAR: exactly 1 cycle with pe_rst_output=1. Next state is FEED if K>0, else DRAIN, yielding an all-zero tile.
- FEED:
  - in_ready=1. A fire is in_valid=1; each fire increments feed_k.
  - in_valid=0 cycles are bubbles: feed_valid=0 and the count holds. PEs pass invalid data without accumulating, so stalls are safe.
  - After the K-th fire, go to FLUSH next cycle; feed_k resets to 0.
- FLUSH:
  - Exactly ROWS+COLS-1 cycles with no feeding and no controls asserted.
  - This covers the skew plus one PE register stage per hop: the last operand reaches PE(ROWS-1,COLS-1) at fire-cycle + ROWS+COLS-2.
  - Then go to DRAIN.
- DRAIN:
  - out_valid=1; pe_shift_out = out_valid && out_ready.
  - Each shift advances out_col. The rightmost PE accumulator_shift input is tied to 0 externally.
  - out_ready=0 holds pe_shift_out=0. With no feed, PEs keep their state and nothing accumulates.
  - After the COLS-th shift, go to DONE.
- DONE:
  - 1 cycle with done=1 and busy=1, then IDLE.
  - A new start is accepted in the following IDLE cycle at the earliest.
- Invariants:
  - pe_shift_out and feed_valid are never high together.
  - pe_rst_output is never high outside CLEAR or reset.
  - feed_k and out_col wrap only through explicit reset to 0.
  - Counters are sized so that K = 2^KW-1 works without overflow.

Test Plan:
- Nominal: ROWS=COLS=4, start with k_len=3, in_valid=1, out_ready=1.
  - Required: 1 CLEAR cycle, 3 FEED fires with feed_k 0,1,2, 7 FLUSH cycles, 4 DRAIN shifts with out_col 0..3, done pulse.
  - busy is high for 16 cycles.
- Feed stall: k_len=4, with in_valid low on the 2nd and 3rd FEED cycles.
  - Required: exactly 4 feed_valid pulses over 6 FEED cycles; feed_k holds during the bubbles.
  - FLUSH still lasts 7 cycles.
- Drain backpressure: out_ready low for 3 cycles after the first shift.
  - Required: pe_shift_out low and out_col held at 1 during those cycles; exactly 4 total shifts.
- Zero-length tile: k_len=0.
  - Required: CLEAR goes directly to DRAIN with no feed_valid; 4 shifts, then done.
- Mid-tile reset: assert rst for 1 cycle during DRAIN after 2 shifts.
  - Required: next cycle in IDLE with busy=0, out_valid=0, out_col=0.
  - pe_rst_output=1 during the reset cycle.
  - A following start runs a full clean tile.
- Start while busy: pulse start during FEED with a different k_len.
  - Required: ignored; the original K governs the fire count, and no extra CLEAR occurs.
